// File: rtl/plcp_pkg.sv
// Shared definitions for the PLCP framer: state codes, field tags and rate table.
// Optional scrambling is selected with PLCP_FRAMER_SCRAMBLE_EN in plcp_framer.
package plcp_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_SIGNAL   = 3'd2;
    localparam logic [2:0] S_SERVICE  = 3'd3;
    localparam logic [2:0] S_PSDU     = 3'd4;
    localparam logic [2:0] S_TAIL     = 3'd5;
    localparam logic [2:0] S_PAD      = 3'd6;

    localparam logic [1:0] PH_PREAMBLE = 2'd0;
    localparam logic [1:0] PH_SIGNAL   = 2'd1;
    localparam logic [1:0] PH_DATA     = 2'd2;
    localparam logic [1:0] PH_IDLE     = 2'd3;

    localparam logic [3:0] RATE_6  = 4'b1101;
    localparam logic [3:0] RATE_9  = 4'b1111;
    localparam logic [3:0] RATE_12 = 4'b0101;
    localparam logic [3:0] RATE_18 = 4'b0111;
    localparam logic [3:0] RATE_24 = 4'b1001;
    localparam logic [3:0] RATE_36 = 4'b1011;
    localparam logic [3:0] RATE_48 = 4'b0001;
    localparam logic [3:0] RATE_54 = 4'b0011;

    localparam int SIGNAL_BITS  = 24;
    localparam int SERVICE_BITS = 16;
    localparam int TAIL_BITS    = 6;

    // Returns data bits per OFDM symbol; zero marks an illegal RATE code.
    function automatic logic [7:0] rate_ndbps(input logic [3:0] rate);
        logic [7:0] n;
        case (rate)
            RATE_6:  n = 8'd24;
            RATE_9:  n = 8'd36;
            RATE_12: n = 8'd48;
            RATE_18: n = 8'd72;
            RATE_24: n = 8'd96;
            RATE_36: n = 8'd144;
            RATE_48: n = 8'd192;
            RATE_54: n = 8'd216;
            default: n = 8'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/plcp_scrambler.sv
// Frame-synchronous x^7+x^4+1 scrambler; reloads seed 7'h7F on load.
module plcp_scrambler (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic advance,
    output logic key
);

    logic [6:0] lfsr;

    assign key = lfsr[6] ^ lfsr[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 7'h7F;
        end else if (load) begin
            lfsr <= 7'h7F;
        end else if (advance) begin
            lfsr <= {lfsr[5:0], key};
        end
    end

endmodule

// File: rtl/plcp_framer.sv
// Serial PLCP frame generator: preamble, SIGNAL, SERVICE, PSDU, tail and pad.
// Define PLCP_FRAMER_SCRAMBLE_EN to scramble data-field bits internally.
module plcp_framer
    import plcp_pkg::*;
#(
    parameter int          PREAMBLE_BITS    = 96,
    parameter logic [7:0]  PREAMBLE_PATTERN = 8'hAA,
    parameter int          LEN_W            = 12
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Rate,
    input  logic [LEN_W-1:0] Length,
    input  logic             DataIn,
    input  logic             DataValid,
    output logic             DataReady,
    output logic             Output,
    output logic             OutValid,
    output logic [1:0]       Phase,
    output logic             Busy,
    output logic             Done,
    output logic             RateErr
);

    localparam int PW = LEN_W + 3;

    logic [2:0]       state;
    logic [3:0]       rate_q;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       ndbps_q;
    logic [15:0]      cnt;
    logic [7:0]       sym;
    logic [PW-1:0]    psdu_cnt;
    logic             done_q;
    logic             rate_err_q;

    logic [7:0]    ndbps_in;
    logic [7:0]    sym_next;
    logic [PW-1:0] psdu_last;
    logic [23:0]   sig;
    logic [7:0]    pat;
    logic          raw;
    logic          pre_last;
    logic          sig_last;

    assign ndbps_in  = rate_ndbps(Rate);
    assign sym_next  = (sym == ndbps_q - 8'd1) ? 8'd0 : sym + 8'd1;
    assign psdu_last = {len_q, 3'b000} - PW'(1);
    assign pat       = PREAMBLE_PATTERN;
    assign pre_last  = (cnt == 16'(PREAMBLE_BITS - 1));
    assign sig_last  = (cnt == 16'(SIGNAL_BITS - 1));

    // sig[i] is the i-th SIGNAL bit on the wire.
    always_comb begin
        sig       = '0;
        sig[0]    = rate_q[3];
        sig[1]    = rate_q[2];
        sig[2]    = rate_q[1];
        sig[3]    = rate_q[0];
        sig[16:5] = 12'(len_q);
        sig[17]   = ^sig[16:0];
    end

    always_comb begin
        raw      = 1'b0;
        OutValid = 1'b0;
        Phase    = PH_DATA;
        case (state)
            S_PREAMBLE: begin
                raw      = pat[~cnt[2:0]];
                OutValid = 1'b1;
                Phase    = PH_PREAMBLE;
            end
            S_SIGNAL: begin
                raw      = sig[cnt[4:0]];
                OutValid = 1'b1;
                Phase    = PH_SIGNAL;
            end
            S_PSDU: begin
                raw      = DataIn;
                OutValid = DataValid;
            end
            S_SERVICE, S_TAIL, S_PAD: begin
                OutValid = 1'b1;
            end
            default: begin
                Phase = PH_IDLE;
            end
        endcase
    end

`ifdef PLCP_FRAMER_SCRAMBLE_EN
    logic key;

    plcp_scrambler u_scrambler (
        .clk     (Clock),
        .rst     (Reset),
        .load    (state == S_SIGNAL && sig_last),
        .advance (OutValid && Phase == PH_DATA),
        .key     (key)
    );

    assign Output = (state == S_TAIL) ? 1'b0
                  : (raw ^ (key && Phase == PH_DATA)) && OutValid;
`else
    assign Output = raw && OutValid;
`endif

    assign DataReady = (state == S_PSDU);
    assign Busy      = (state != S_IDLE);
    assign Done      = done_q;
    assign RateErr   = rate_err_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            rate_q     <= '0;
            len_q      <= '0;
            ndbps_q    <= '0;
            cnt        <= '0;
            sym        <= '0;
            psdu_cnt   <= '0;
            done_q     <= 1'b0;
            rate_err_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rate_err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (ndbps_in != 8'd0) begin
                            state    <= S_PREAMBLE;
                            rate_q   <= Rate;
                            len_q    <= Length;
                            ndbps_q  <= ndbps_in;
                            cnt      <= '0;
                            sym      <= '0;
                            psdu_cnt <= '0;
                        end else begin
                            rate_err_q <= 1'b1;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (pre_last) begin
                        state <= S_SIGNAL;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_SIGNAL: begin
                    if (sig_last) begin
                        state <= S_SERVICE;
                        cnt   <= '0;
                        sym   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_SERVICE: begin
                    sym <= sym_next;
                    if (cnt == 16'(SERVICE_BITS - 1)) begin
                        cnt   <= '0;
                        state <= (len_q == '0) ? S_TAIL : S_PSDU;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_PSDU: begin
                    if (DataValid) begin
                        sym <= sym_next;
                        if (psdu_cnt == psdu_last) begin
                            state    <= S_TAIL;
                            psdu_cnt <= '0;
                        end else begin
                            psdu_cnt <= psdu_cnt + PW'(1);
                        end
                    end
                end
                S_TAIL: begin
                    sym <= sym_next;
                    if (cnt == 16'(TAIL_BITS - 1)) begin
                        cnt <= '0;
                        if (sym_next == 8'd0) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            state <= S_PAD;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_PAD: begin
                    sym <= sym_next;
                    if (sym_next == 8'd0) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plcp_framer.sv
// Randomized bench for plcp_framer against a queue-based frame model.
module tb_plcp_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  rate;
    logic [11:0] length;
    logic        data_in;
    logic        data_valid;
    logic        data_ready;
    logic        out_bit;
    logic        out_valid;
    logic [1:0]  phase;
    logic        busy;
    logic        done;
    logic        rate_err;

    int checks = 0;
    int failures = 0;
    bit ok;

    bit         exp_b[$];
    logic [1:0] exp_p[$];
    bit         dat[$];

    logic [3:0] legal_rates [8] = '{4'b1101, 4'b1111, 4'b0101, 4'b0111,
                                    4'b1001, 4'b1011, 4'b0001, 4'b0011};

    always #5 clk = ~clk;

    plcp_framer dut (
        .Clock     (clk),
        .Reset     (rst),
        .Start     (start),
        .Rate      (rate),
        .Length    (length),
        .DataIn    (data_in),
        .DataValid (data_valid),
        .DataReady (data_ready),
        .Output    (out_bit),
        .OutValid  (out_valid),
        .Phase     (phase),
        .Busy      (busy),
        .Done      (done),
        .RateErr   (rate_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        ok = (got === exp);
        if (!ok) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int nd_of(input logic [3:0] r);
        case (r)
            4'b1101: return 24;
            4'b1111: return 36;
            4'b0101: return 48;
            4'b0111: return 72;
            4'b1001: return 96;
            4'b1011: return 144;
            4'b0001: return 192;
            4'b0011: return 216;
            default: return 0;
        endcase
    endfunction

    task automatic push(input bit b, input logic [1:0] p);
        exp_b.push_back(b);
        exp_p.push_back(p);
    endtask

    task automatic build_model(input logic [3:0] r, input int len);
        logic [7:0] pat;
        int ones;
        int ndata;
        int nd;
        pat = 8'hAA;
        nd = nd_of(r);
        exp_b.delete();
        exp_p.delete();
        for (int i = 0; i < 96; i++) push(pat[7 - (i % 8)], 2'd0);
        ones = 0;
        for (int i = 3; i >= 0; i--) begin
            push(r[i], 2'd1);
            ones += r[i];
        end
        push(1'b0, 2'd1);
        for (int i = 0; i < 12; i++) begin
            push(bit'((len >> i) & 1), 2'd1);
            ones += (len >> i) & 1;
        end
        push(bit'(ones % 2), 2'd1);
        for (int i = 0; i < 6; i++) push(1'b0, 2'd1);
        for (int i = 0; i < 16; i++) push(1'b0, 2'd2);
        for (int i = 0; i < dat.size(); i++) push(dat[i], 2'd2);
        for (int i = 0; i < 6; i++) push(1'b0, 2'd2);
        ndata = 22 + 8 * len;
        while (ndata % nd != 0) begin
            push(1'b0, 2'd2);
            ndata++;
        end
    endtask

    task automatic chk_reset(input string pre);
        chk({pre, "_out"}, out_bit, 0);
        chk({pre, "_ovalid"}, out_valid, 0);
        chk({pre, "_ready"}, data_ready, 0);
        chk({pre, "_phase"}, phase, 3);
        chk({pre, "_busy"}, busy, 0);
        chk({pre, "_done"}, done, 0);
        chk({pre, "_rerr"}, rate_err, 0);
    endtask

    // Called at a negedge with the DUT idle or in its Done cycle.
    task automatic do_frame(input logic [3:0] r, input int len,
                            input int mode, input bit poke);
        bit got_b[$];
        logic [1:0] got_p[$];
        int cyc, di, first, gaps, xfer, bad_rdy, bad_gap, busy_lo, errs, n;
        bit fin;
        dat.delete();
        for (int i = 0; i < 8 * len; i++) dat.push_back(bit'($urandom % 2));
        build_model(r, len);
        start = 1'b1;
        rate = r;
        length = 12'(len);
        cyc = 0; di = 0; first = -1; gaps = 0; xfer = 0;
        bad_rdy = 0; bad_gap = 0; busy_lo = 0; errs = 0; fin = 0;
        while (!fin && cyc < 5000) begin
            @(posedge clk);
            #1;
            start = poke && (cyc == 10);
            rate = 4'($urandom);
            length = 12'($urandom);
            case (mode)
                0: data_valid = 1'b1;
                1: data_valid = (cyc % 2 == 0);
                default: data_valid = bit'($urandom % 2);
            endcase
            data_in = (di < dat.size()) ? dat[di] : bit'($urandom % 2);
            @(negedge clk);
            cyc++;
            if (done) begin
                fin = 1;
            end else begin
                if (!busy) busy_lo++;
                if (rate_err) errs++;
                if (out_valid) begin
                    got_b.push_back(out_bit);
                    got_p.push_back(phase);
                    if (first < 0) first = cyc;
                end
                if (data_ready && phase != 2'd2) bad_rdy++;
                if (data_ready && out_valid != data_valid) bad_gap++;
                if (data_ready && !data_valid) gaps++;
                if (data_ready && data_valid) begin
                    xfer++;
                    di++;
                end
            end
        end
        start = 1'b0;
        chk("done_seen", fin, 1);
        chk("first_lat", first, 1);
        chk("busy_gap", busy_lo, 0);
        chk("rate_err_in_frame", errs, 0);
        chk("ready_phase", bad_rdy, 0);
        chk("valid_gap", bad_gap, 0);
        chk("psdu_xfer", xfer, 8 * len);
        chk("nbits", got_b.size(), exp_b.size());
        chk("done_lat", cyc, exp_b.size() + gaps + 1);
        chk("done_busy", busy, 0);
        chk("done_ovalid", out_valid, 0);
        n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("bit%0d", i), {got_p[i], got_b[i]},
                {exp_p[i], exp_b[i]});
            if (!ok) break;
        end
    endtask

    task automatic rate_err_test();
        logic [3:0] r;
        r = 4'($urandom);
        while (nd_of(r) != 0) r = 4'($urandom);
        start = 1'b1;
        rate = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("rerr_pulse", rate_err, 1);
        chk("rerr_busy", busy, 0);
        chk("rerr_ovalid", out_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rerr_clear", rate_err, 0);
        chk("rerr_busy2", busy, 0);
    endtask

    task automatic reset_mid();
        int xfer;
        int cyc;
        start = 1'b1;
        rate = legal_rates[$urandom % 8];
        length = 12'd2;
        xfer = 0;
        cyc = 0;
        while (cyc < 400) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            data_valid = 1'b1;
            data_in = bit'($urandom % 2);
            if (xfer == 5) rst = 1'b1;
            @(negedge clk);
            cyc++;
            if (rst) break;
            if (data_ready && data_valid) xfer++;
        end
        chk("mid_reset_reached", rst, 1);
        chk_reset("mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset("post");
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rate = '0;
        length = '0;
        data_in = 1'b0;
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst = 1'b0;
        do_frame(4'b1101, 16, 0, 0);
        do_frame(4'b0011, 0, 0, 0);
        rate_err_test();
        do_frame(legal_rates[$urandom % 8], 2, 1, 0);
        do_frame(legal_rates[$urandom % 8], $urandom_range(1, 12), 0, 1);
        reset_mid();
        do_frame(legal_rates[$urandom % 8], 3, 2, 0);
        for (int k = 0; k < 6; k++) begin
            do_frame(legal_rates[$urandom % 8], $urandom_range(0, 20),
                     2, bit'($urandom % 2));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
